mem_bus_arbiter: RTL

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter_if.sv | 47 ++++
 rtl/mem_bus_arbiter.sv | 122 ++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - two-requester shared memory bus signal bundle
`ifndef SIZE_OF_THE_BUS
`define SIZE_OF_THE_BUS 32
`endif

interface mem_bus_arbiter_if;
  logic                        m0_valid;
  logic                        m0_instr;
  logic [`SIZE_OF_THE_BUS-1:0] m0_addr;
  logic [`SIZE_OF_THE_BUS-1:0] m0_wdata;
  logic [3:0]                  m0_wstrb;
  logic                        m0_ready;
  logic [`SIZE_OF_THE_BUS-1:0] m0_rdata;

  logic                        m1_valid;
  logic                        m1_instr;
  logic [`SIZE_OF_THE_BUS-1:0] m1_addr;
  logic [`SIZE_OF_THE_BUS-1:0] m1_wdata;
  logic [3:0]                  m1_wstrb;
  logic                        m1_ready;
  logic [`SIZE_OF_THE_BUS-1:0] m1_rdata;

  logic                        mem_valid;
  logic                        mem_instr;
  logic [`SIZE_OF_THE_BUS-1:0] mem_addr;
  logic [`SIZE_OF_THE_BUS-1:0] mem_wdata;
  logic [3:0]                  mem_wstrb;
  logic                        mem_ready;
  logic [`SIZE_OF_THE_BUS-1:0] mem_rdata;

  // Arbiter side: serves both requesters and drives the shared memory request.
  modport slave (
    input  m0_valid, m0_instr, m0_addr, m0_wdata, m0_wstrb,
    input  m1_valid, m1_instr, m1_addr, m1_wdata, m1_wstrb,
    input  mem_ready, mem_rdata,
    output m0_ready, m0_rdata, m1_ready, m1_rdata,
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb
  );

  modport master (
    output m0_valid, m0_instr, m0_addr, m0_wdata, m0_wstrb,
    output m1_valid, m1_instr, m1_addr, m1_wdata, m1_wstrb,
    output mem_ready, mem_rdata,
    input  m0_ready, m0_rdata, m1_ready, m1_rdata,
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - round-robin two-requester memory bus arbiter
// Optional grant watchdog enabled by defining ARB_TIMEOUT_EN.
`ifndef SIZE_OF_THE_BUS
`define SIZE_OF_THE_BUS 32
`endif

module mem_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              resetn,
  mem_bus_arbiter_if.slave  bus,
  output logic              timeout_err
);
  localparam int DW = `SIZE_OF_THE_BUS;

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_e;

  state_e state_q;
  logic   last_grant_q;  // 1: m1 was served last, so m0 wins a tie
  logic   gnt_valid;
  logic   done_ok;
  logic   tmo_hit;
  logic   xfer_done;
  logic   pick_m1;

  always_comb begin
    gnt_valid     = 1'b0;
    bus.mem_valid = 1'b0;
    bus.mem_instr = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wstrb = '0;
    case (state_q)
      GNT0: begin
        gnt_valid     = bus.m0_valid;
        bus.mem_valid = bus.m0_valid;
        bus.mem_instr = bus.m0_instr;
        bus.mem_addr  = bus.m0_addr;
        bus.mem_wdata = bus.m0_wdata;
        bus.mem_wstrb = bus.m0_wstrb;
      end
      GNT1: begin
        gnt_valid     = bus.m1_valid;
        bus.mem_valid = bus.m1_valid;
        bus.mem_instr = bus.m1_instr;
        bus.mem_addr  = bus.m1_addr;
        bus.mem_wdata = bus.m1_wdata;
        bus.mem_wstrb = bus.m1_wstrb;
      end
      default: ;
    endcase
  end

  assign done_ok   = gnt_valid & bus.mem_ready;
  assign xfer_done = done_ok | tmo_hit;
  assign pick_m1   = bus.m1_valid & (~bus.m0_valid | ~last_grant_q);

  // A timed-out transfer completes with zero read data.
  assign bus.m0_ready = (state_q == GNT0) & xfer_done;
  assign bus.m1_ready = (state_q == GNT1) & xfer_done;
  assign bus.m0_rdata = ((state_q == GNT0) && done_ok) ? bus.mem_rdata : {DW{1'b0}};
  assign bus.m1_rdata = ((state_q == GNT1) && done_ok) ? bus.mem_rdata : {DW{1'b0}};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.m0_valid || bus.m1_valid) begin
            state_q <= pick_m1 ? GNT1 : GNT0;
          end
        end
        GNT0, GNT1: begin
          if (!gnt_valid) begin
            state_q <= IDLE;
          end else if (xfer_done) begin
            state_q      <= IDLE;
            last_grant_q <= (state_q == GNT1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] cnt_q;
  logic          timeout_err_q;

  assign tmo_hit     = gnt_valid & ~bus.mem_ready & (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign timeout_err = timeout_err_q;

  // Held at zero in IDLE so every grant starts counting from its first cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      if (state_q == IDLE) begin
        cnt_q <= '0;
      end else if (gnt_valid && !bus.mem_ready && !tmo_hit) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (tmo_hit) begin
        timeout_err_q <= 1'b1;
      end
    end
  end
`else
  logic unused_cfg;

  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
  assign unused_cfg  = (TIMEOUT_CYCLES == 0);
`endif

endmodule
